// File: rtl/cpu_bank_reg.sv
// Purpose : register bank with two write ports, two combinational read ports and a multiply scoreboard.
// Latency : reads and busy flags are zero-latency; writes, sets and clears take effect at the next rising edge.
// Backpres: none. Every enabled write, set or clear is accepted in the cycle it is presented.
//
// Ports:
//   clock, reset             sole clock; asynchronous active-low reset
//   write_enable/_reg/_data  primary (ALU/memory) write port; wins every index conflict
//   write_*_mul              multiplier writeback port; also clears the busy bit of its index
//   read_reg_a/b             read indices -> read_data_a/b, busy_a/b (with same-cycle bypass)
//   mul_issue/_reg           marks a register as awaiting a multiply result
//   busy_any                 OR of all scoreboard bits held in the register state
module cpu_bank_reg #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 32,
  localparam int REG_BITS  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  write_enable,
  input  logic [REG_BITS-1:0]   write_reg,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  write_enable_mul,
  input  logic [REG_BITS-1:0]   write_reg_mul,
  input  logic [DATA_WIDTH-1:0] write_data_mul,
  input  logic [REG_BITS-1:0]   read_reg_a,
  input  logic [REG_BITS-1:0]   read_reg_b,
  output logic [DATA_WIDTH-1:0] read_data_a,
  output logic [DATA_WIDTH-1:0] read_data_b,
  input  logic                  mul_issue,
  input  logic [REG_BITS-1:0]   mul_issue_reg,
  output logic                  busy_a,
  output logic                  busy_b,
  output logic                  busy_any
);

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
  logic [NUM_REGS-1:0]   busy_q;
  logic [NUM_REGS-1:0]   busy_d;
  logic                  busy_any_q;
  logic                  busy_any_d;

  // One-hot decodes of each port. Indices that do not match any entry
  // (index >= NUM_REGS) decode to all-zero and are therefore ignored.
  logic [NUM_REGS-1:0] wr_hit;
  logic [NUM_REGS-1:0] mul_hit;
  logic [NUM_REGS-1:0] set_hit;
  // Busy bit as seen by a reader this cycle: a clear already counts,
  // a set does not show until it has been registered.
  logic [NUM_REGS-1:0] busy_view;

  always_comb begin
    wr_hit  = '0;
    mul_hit = '0;
    set_hit = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      wr_hit[i]  = write_enable     && (write_reg     == REG_BITS'(i));
      mul_hit[i] = write_enable_mul && (write_reg_mul == REG_BITS'(i));
      set_hit[i] = mul_issue        && (mul_issue_reg == REG_BITS'(i));
    end
  end

  // Next state. The primary port beats the multiplier port because the
  // multiply result belongs to the older instruction. A new issue beats a
  // writeback of the same index: the new multiply is still outstanding.
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = regs_q[i];
      if (wr_hit[i]) begin
        regs_d[i] = write_data;
      end else if (mul_hit[i]) begin
        regs_d[i] = write_data_mul;
      end
    end
    busy_d     = set_hit | (busy_q & ~mul_hit);
    busy_view  = busy_q & ~(mul_hit & ~set_hit);
    busy_any_d = |busy_d;
  end

  // Reads bypass through the next-state value, which already carries the
  // prioritised write data for a matching index. Unmatched indices read 0.
  always_comb begin
    read_data_a = '0;
    read_data_b = '0;
    busy_a      = 1'b0;
    busy_b      = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (read_reg_a == REG_BITS'(i)) begin
        read_data_a = regs_d[i];
        busy_a      = busy_view[i];
      end
      if (read_reg_b == REG_BITS'(i)) begin
        read_data_b = regs_d[i];
        busy_b      = busy_view[i];
      end
    end
  end

  assign busy_any = busy_any_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
      busy_q     <= '0;
      busy_any_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
      busy_q     <= busy_d;
      busy_any_q <= busy_any_d;
    end
  end

endmodule
